hearts_lives_ctrl: RTL and testbench

HEARTS_LIVES_CTRL -- requirements
Module: hearts_lives_ctrl

---
 rtl/hearts_pkg.sv | 13 +
 rtl/heart_slot_hit.sv | 28 ++
 rtl/hearts_lives_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hearts_lives_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hearts_pkg.sv
// rtl/hearts_pkg.sv - shared types and constants for the hearts/lives HUD controller
package hearts_pkg;

  typedef enum logic [1:0] {
    ALIVE    = 2'd0,
    COOLDOWN = 2'd1,
    DEAD     = 2'd2
  } state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'h05;
  localparam int         LIVES_W              = 4;

endpackage

// File: rtl/heart_slot_hit.sv
// rtl/heart_slot_hit.sv - combinational bounding-box test for one heart slot
module heart_slot_hit #(
  parameter int SLOT_X = 16,
  parameter int SLOT_Y = 16,
  parameter int SLOT_W = 32,
  parameter int SLOT_H = 32
) (
  input  logic signed [10:0] pixel_x_i,
  input  logic signed [10:0] pixel_y_i,
  output logic               inside_o,
  output logic        [10:0] offset_x_o,
  output logic        [10:0] offset_y_o
);

  // Sign-extend so negative pixel coordinates never alias into the row.
  logic signed [31:0] px;
  logic signed [31:0] py;

  assign px = {{21{pixel_x_i[10]}}, pixel_x_i};
  assign py = {{21{pixel_y_i[10]}}, pixel_y_i};

  assign inside_o = (px >= SLOT_X) && (px < SLOT_X + SLOT_W) &&
                    (py >= SLOT_Y) && (py < SLOT_Y + SLOT_H);

  assign offset_x_o = 11'(px - SLOT_X);
  assign offset_y_o = 11'(py - SLOT_Y);

endmodule

// File: rtl/hearts_lives_ctrl.sv
// rtl/hearts_lives_ctrl.sv - life counter FSM with blinking heart-row renderer
// Optional feature macro: HEARTS_BONUS_EN (bonus pulses add lives when defined).
module hearts_lives_ctrl
  import hearts_pkg::*;
#(
  parameter int         MAX_LIVES     = 3,
  parameter int         INIT_LIVES    = 3,
  parameter int         HEART_W       = 32,
  parameter int         HEART_H       = 32,
  parameter int         HEART_GAP     = 8,
  parameter logic [10:0] TOP_LEFT_X   = 11'd16,
  parameter logic [10:0] TOP_LEFT_Y   = 11'd16,
  parameter int         INVULN_FRAMES = 60,
  parameter int         BLINK_SHIFT   = 3,
  parameter logic [7:0] HEART_COLOR   = 8'h5b
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      hit,
  input  logic                      bonus,
  input  logic                      restart,
  input  logic signed [10:0]        pixelX,
  input  logic signed [10:0]        pixelY,
  output logic        [10:0]        offsetX,
  output logic        [10:0]        offsetY,
  output logic                      drawingRequest,
  output logic        [7:0]         RGBout,
  output logic        [LIVES_W-1:0] lives,
  output logic                      invulnerable,
  output logic                      gameOver
);

  localparam int FC_BITS = $clog2(INVULN_FRAMES + 1);
  localparam int FC_W    = (FC_BITS > BLINK_SHIFT + 1) ? FC_BITS : BLINK_SHIFT + 1;

  state_t              state_q;
  logic [LIVES_W-1:0]  lives_q;
  logic [FC_W-1:0]     frame_cnt_q;
  logic                invuln_q;
  logic                game_over_q;

  logic                bonus_acc;
`ifdef HEARTS_BONUS_EN
  assign bonus_acc = bonus;
`else
  logic unused_bonus;
  assign bonus_acc    = 1'b0;
  assign unused_bonus = bonus;
`endif

  logic lives_below_max;
  assign lives_below_max = lives_q < LIVES_W'(MAX_LIVES);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ALIVE;
      lives_q     <= LIVES_W'(INIT_LIVES);
      frame_cnt_q <= '0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else if (restart) begin
      state_q     <= ALIVE;
      lives_q     <= LIVES_W'(INIT_LIVES);
      frame_cnt_q <= '0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ALIVE: begin
          // A hit takes priority; a simultaneous bonus is dropped.
          if (hit) begin
            if (lives_q > LIVES_W'(1)) begin
              lives_q     <= lives_q - LIVES_W'(1);
              frame_cnt_q <= '0;
              state_q     <= COOLDOWN;
              invuln_q    <= 1'b1;
            end else begin
              lives_q     <= '0;
              state_q     <= DEAD;
              game_over_q <= 1'b1;
            end
          end else if (bonus_acc && lives_below_max) begin
            lives_q <= lives_q + LIVES_W'(1);
          end
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            if (frame_cnt_q == FC_W'(INVULN_FRAMES - 1)) begin
              frame_cnt_q <= '0;
              state_q     <= ALIVE;
              invuln_q    <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + FC_W'(1);
            end
          end
          if (bonus_acc && lives_below_max) begin
            lives_q <= lives_q + LIVES_W'(1);
          end
        end
        DEAD: begin
          game_over_q <= 1'b1;
        end
        default: begin
          state_q <= ALIVE;
        end
      endcase
    end
  end

  assign lives        = lives_q;
  assign invulnerable = invuln_q;
  assign gameOver     = game_over_q;

  logic [MAX_LIVES-1:0] slot_in;
  logic [10:0]          slot_ox [MAX_LIVES];
  logic [10:0]          slot_oy [MAX_LIVES];

  for (genvar i = 0; i < MAX_LIVES; i++) begin : g_slot
    heart_slot_hit #(
      .SLOT_X(int'(TOP_LEFT_X) + i * (HEART_W + HEART_GAP)),
      .SLOT_Y(int'(TOP_LEFT_Y)),
      .SLOT_W(HEART_W),
      .SLOT_H(HEART_H)
    ) u_slot (
      .pixel_x_i (pixelX),
      .pixel_y_i (pixelY),
      .inside_o  (slot_in[i]),
      .offset_x_o(slot_ox[i]),
      .offset_y_o(slot_oy[i])
    );
  end

  logic        blink_off;
  logic        draw_d;
  logic [10:0] off_x_d;
  logic [10:0] off_y_d;
  logic [7:0]  rgb_d;

  assign blink_off = (state_q == COOLDOWN) && frame_cnt_q[BLINK_SHIFT];

  // Slots never overlap, so at most one iteration can fire.
  always_comb begin
    draw_d  = 1'b0;
    off_x_d = '0;
    off_y_d = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      if (slot_in[i] && (LIVES_W'(i) < lives_q) && !blink_off) begin
        draw_d  = 1'b1;
        off_x_d = slot_ox[i];
        off_y_d = slot_oy[i];
      end
    end
    rgb_d = draw_d ? HEART_COLOR : TRANSPARENT_ENCODING;
  end

  logic        draw_q;
  logic [10:0] off_x_q;
  logic [10:0] off_y_q;
  logic [7:0]  rgb_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q  <= 1'b0;
      off_x_q <= '0;
      off_y_q <= '0;
      rgb_q   <= 8'h00;
    end else begin
      draw_q  <= draw_d;
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
      rgb_q   <= rgb_d;
    end
  end

  assign drawingRequest = draw_q;
  assign offsetX        = off_x_q;
  assign offsetY        = off_y_q;
  assign RGBout         = rgb_q;

endmodule

// File: tb/tb_hearts_lives_ctrl.sv
// tb/tb_hearts_lives_ctrl.sv - scoreboard bench for hearts_lives_ctrl
module tb_hearts_lives_ctrl;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               hit = 1'b0;
  logic               bonus = 1'b0;
  logic               restart = 1'b0;
  logic signed [10:0] pixelX = '0;
  logic signed [10:0] pixelY = '0;
  logic        [10:0] offsetX;
  logic        [10:0] offsetY;
  logic               drawingRequest;
  logic        [7:0]  RGBout;
  logic        [3:0]  lives;
  logic               invulnerable;
  logic               gameOver;

  hearts_lives_ctrl dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .hit           (hit),
    .bonus         (bonus),
    .restart       (restart),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .drawingRequest(drawingRequest),
    .RGBout        (RGBout),
    .lives         (lives),
    .invulnerable  (invulnerable),
    .gameOver      (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         draw;
    logic [7:0] rgb;
    int         ox;
    int         oy;
    int         lv;
    bit         inv;
    bit         go;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic probe    = 1'b0;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: one cycle after a probed pixel, the registered outputs are valid.
  initial begin
    forever begin
      @(posedge clk);
      if (probe) begin
        @(negedge clk);
        if (q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow actual=0 required=1");
        end else begin
          exp_t e;
          e = q.pop_front();
          cmp(e.name, "draw", int'(drawingRequest), int'(e.draw));
          cmp(e.name, "rgb", int'(RGBout), int'(e.rgb));
          cmp(e.name, "offx", int'(offsetX), e.ox);
          cmp(e.name, "offy", int'(offsetY), e.oy);
          cmp(e.name, "lives", int'(lives), e.lv);
          cmp(e.name, "inv", int'(invulnerable), int'(e.inv));
          cmp(e.name, "go", int'(gameOver), int'(e.go));
        end
      end
    end
  end

  task automatic check_px(input string nm, input int x, input int y, input bit d,
                          input logic [7:0] rgb, input int ox, input int oy,
                          input int lv, input bit inv, input bit go);
    exp_t e;
    @(posedge clk); #1;
    pixelX = 11'(x);
    pixelY = 11'(y);
    probe  = 1'b1;
    e.name = nm; e.draw = d; e.rgb = rgb; e.ox = ox; e.oy = oy;
    e.lv = lv; e.inv = inv; e.go = go;
    q.push_back(e);
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic pulse(input bit h, input bit b, input bit r, input bit s);
    @(posedge clk); #1;
    hit = h; bonus = b; restart = r; startOfFrame = s;
    @(posedge clk); #1;
    hit = 1'b0; bonus = 1'b0; restart = 1'b0; startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  localparam logic [7:0] C = 8'h5b;
  localparam logic [7:0] T = 8'h05;

  initial begin
    int lv;
    repeat (2) @(posedge clk);
    check_px("reset_hold", 16, 16, 0, 8'h00, 0, 0, 3, 0, 0);
    @(posedge clk); #1;
    resetN = 1'b1;

    check_px("slot0_corner", 16, 16, 1, C, 0, 0, 3, 0, 0);
    check_px("gap_50_20", 50, 20, 0, T, 0, 0, 3, 0, 0);
    check_px("slot1_inner", 60, 30, 1, C, 4, 14, 3, 0, 0);
    check_px("slot2_far_corner", 127, 47, 1, C, 31, 31, 3, 0, 0);
    check_px("right_of_row", 128, 20, 0, T, 0, 0, 3, 0, 0);
    check_px("below_row", 16, 48, 0, T, 0, 0, 3, 0, 0);
    check_px("left_edge_minus1", 15, 16, 0, T, 0, 0, 3, 0, 0);
    check_px("negative_x", -5, 20, 0, T, 0, 0, 3, 0, 0);
    check_px("above_row", 20, 15, 0, T, 0, 0, 3, 0, 0);

    pulse(1, 0, 0, 0);
    check_px("hit1_frame0", 16, 16, 1, C, 0, 0, 2, 1, 0);
    check_px("hit1_slot2_gone", 100, 20, 0, T, 0, 0, 2, 1, 0);
    frames(7);
    check_px("cool_frame7_vis", 16, 16, 1, C, 0, 0, 2, 1, 0);
    frames(1);
    check_px("cool_frame8_hid", 16, 16, 0, T, 0, 0, 2, 1, 0);
    pulse(1, 0, 0, 0);
    check_px("hit_ignored_cool", 20, 20, 0, T, 0, 0, 2, 1, 0);
    frames(8);
    check_px("cool_frame16_vis", 16, 16, 1, C, 0, 0, 2, 1, 0);
    frames(43);
    check_px("cool_frame59", 16, 16, 0, T, 0, 0, 2, 1, 0);
    frames(1);
    check_px("cool_done", 16, 16, 1, C, 0, 0, 2, 0, 0);

    pulse(1, 1, 0, 0);
    check_px("hit_and_bonus", 16, 16, 1, C, 0, 0, 1, 1, 0);
`ifdef HEARTS_BONUS_EN
    lv = 2;
`else
    lv = 1;
`endif
    pulse(0, 1, 0, 0);
    check_px("bonus_in_cool", 60, 16, lv > 1, lv > 1 ? C : T, lv > 1 ? 4 : 0, 0, lv, 1, 0);
    frames(60);
    check_px("cool2_done", 16, 16, 1, C, 0, 0, lv, 0, 0);
    if (lv == 2) begin
      pulse(1, 0, 0, 0);
      frames(61);
      check_px("pre_death", 16, 16, 1, C, 0, 0, 1, 0, 0);
    end
    pulse(1, 0, 0, 0);
    check_px("dead", 16, 16, 0, T, 0, 0, 0, 0, 1);
    pulse(1, 1, 0, 0);
    pulse(0, 1, 0, 0);
    check_px("dead_ignores", 16, 16, 0, T, 0, 0, 0, 0, 1);

    pulse(0, 0, 1, 0);
    check_px("restart", 16, 16, 1, C, 0, 0, 3, 0, 0);
    pulse(0, 1, 0, 0);
    check_px("bonus_saturate", 100, 20, 1, C, 4, 4, 3, 0, 0);
    pulse(1, 0, 1, 0);
    check_px("restart_beats_hit", 16, 16, 1, C, 0, 0, 3, 0, 0);

    pulse(1, 0, 0, 0);
    frames(30);
    check_px("cool_frame30_hid", 16, 16, 0, T, 0, 0, 2, 1, 0);
    @(posedge clk); #1;
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    check_px("reset_mid_cool", 16, 16, 1, C, 0, 0, 3, 0, 0);

    repeat (3) @(posedge clk);
    cmp("scoreboard", "drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
